common_decinc_counter: RTL and testbench

COMMON_DECINC_COUNTER -- requirements
Module: common_decinc_counter

---
 rtl/common_decinc_counter.sv | 120 ++++++++++++
 tb/tb_common_decinc_counter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/common_decinc_counter.sv
// ---------------------------------------------------------------------------
// common_decinc_counter
//
// Up/down counter with wrap or saturate behaviour, a one-cycle carry/borrow
// pulse and a sticky overflow flag.
//
// Optional feature macro: COMMON_DECINC_COUNTER_LOAD_EN
//   When defined, the load/load_d ports and the parallel-load path exist.
//   When undefined, both ports and the load path are absent.
//
// Parameters
//   WIDTH       counter width in bits (2..16)
//   SATURATE    0 = wrap modulo 2^WIDTH, 1 = clamp at 0 / 2^WIDTH-1
//   RESET_VALUE counter value after reset
//
// Ports
//   clk      in   sole clock, rising edge
//   reset    in   synchronous, active-high reset
//   en       in   count enable, qualifies inc/dec
//   inc      in   request +1
//   dec      in   request -1
//   load     in   load request             (LOAD_EN builds only)
//   load_d   in   load value, WIDTH bits   (LOAD_EN builds only)
//   q        out  registered counter value
//   c        out  registered one-cycle carry/borrow pulse
//   ovf      out  sticky flag, set whenever c asserts
//   is_zero  out  combinational q == 0
//   is_max   out  combinational q == 2^WIDTH-1
// ---------------------------------------------------------------------------
module common_decinc_counter #(
    parameter int unsigned      WIDTH       = 4,
    parameter bit               SATURATE    = 1'b0,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             inc,
    input  logic             dec,
`ifdef COMMON_DECINC_COUNTER_LOAD_EN
    input  logic             load,
    input  logic [WIDTH-1:0] load_d,
`endif
    output logic [WIDTH-1:0] q,
    output logic             c,
    output logic             ovf,
    output logic             is_zero,
    output logic             is_max
);

    if (WIDTH < 2 || WIDTH > 16) begin : g_width_check
        $error("common_decinc_counter: WIDTH must be in 2..16");
    end

    // One step in WIDTH+1 bits: the top bit is the carry on increment and
    // the borrow on decrement (0 - 1 sets every bit, including the top).
    function automatic logic [WIDTH:0] step_ext(input logic [WIDTH-1:0] cur,
                                                 input logic             up);
        logic [WIDTH:0] ext;
        logic [WIDTH:0] one;
        one = {{WIDTH{1'b0}}, 1'b1};
        ext = {1'b0, cur};
        return up ? (ext + one) : (ext - one);
    endfunction

    // Apply the wrap/clamp policy to a stepped value.
    function automatic logic [WIDTH-1:0] sat_value(input logic [WIDTH:0]   ext,
                                                   input logic [WIDTH-1:0] cur);
        if (SATURATE && ext[WIDTH]) begin
            return cur;
        end
        return ext[WIDTH-1:0];
    endfunction

    logic [WIDTH-1:0] count_p1;
    logic             c_p1;
    logic             ovf_p1;

    logic             step_req;
    logic [WIDTH:0]   stepped;
    logic [WIDTH-1:0] next_count;
    logic             carry;

    always_comb begin
        step_req   = en & (inc ^ dec);
        stepped    = step_ext(count_p1, inc);
        next_count = sat_value(stepped, count_p1);
        carry      = stepped[WIDTH];
    end

    // ---- stage p1: counter, pulse and sticky flag registers ----
    always_ff @(posedge clk) begin
        if (reset) begin
            count_p1 <= RESET_VALUE;
            c_p1     <= 1'b0;
            ovf_p1   <= 1'b0;
        end
`ifdef COMMON_DECINC_COUNTER_LOAD_EN
        else if (load) begin
            count_p1 <= load_d;
            c_p1     <= 1'b0;
            ovf_p1   <= 1'b0;
        end
`endif
        else if (step_req) begin
            count_p1 <= next_count;
            c_p1     <= carry;
            ovf_p1   <= ovf_p1 | carry;
        end else begin
            c_p1     <= 1'b0;
        end
    end

    assign q       = count_p1;
    assign c       = c_p1;
    assign ovf     = ovf_p1;
    assign is_zero = (count_p1 == '0);
    assign is_max  = (count_p1 == '1);

endmodule

// File: tb/tb_common_decinc_counter.sv
module tb_common_decinc_counter;

    typedef struct {
        logic       r, e, i, d, l;
        logic [3:0] ld;
        logic [3:0] q;
        logic       c, o;
        string      tag;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: wrap, RESET_VALUE 0. Instance B: saturate, RESET_VALUE 3.
    logic       ra = 1'b0, ea = 1'b0, ia = 1'b0, da = 1'b0;
    logic       rb = 1'b0, eb = 1'b0, ib = 1'b0, db = 1'b0;
`ifdef COMMON_DECINC_COUNTER_LOAD_EN
    logic       la = 1'b0, lb = 1'b0;
    logic [3:0] lda = 4'd0, ldb = 4'd0;
`endif
    logic [3:0] qa, qb;
    logic       ca, cb, oa, ob, za, zb, ma, mb;

    common_decinc_counter #(.WIDTH(4), .SATURATE(1'b0), .RESET_VALUE(4'd0)) dut_a (
        .clk(clk), .reset(ra), .en(ea), .inc(ia), .dec(da),
`ifdef COMMON_DECINC_COUNTER_LOAD_EN
        .load(la), .load_d(lda),
`endif
        .q(qa), .c(ca), .ovf(oa), .is_zero(za), .is_max(ma));

    common_decinc_counter #(.WIDTH(4), .SATURATE(1'b1), .RESET_VALUE(4'd3)) dut_b (
        .clk(clk), .reset(rb), .en(eb), .inc(ib), .dec(db),
`ifdef COMMON_DECINC_COUNTER_LOAD_EN
        .load(lb), .load_d(ldb),
`endif
        .q(qb), .c(cb), .ovf(ob), .is_zero(zb), .is_max(mb));

    int   n_vec = 0;
    int   n_err = 0;
    vec_t exp_a[$];
    vec_t exp_b[$];
    vec_t tbl[$];

    function automatic vec_t mk(logic r, e, i, d, logic [3:0] q, logic c, o, string tag);
        vec_t v;
        v.r = r; v.e = e; v.i = i; v.d = d; v.l = 1'b0; v.ld = 4'd0;
        v.q = q; v.c = c; v.o = o; v.tag = tag;
        return v;
    endfunction

    function automatic vec_t mkl(logic r, e, i, d, logic [3:0] ld, logic [3:0] q,
                                 logic c, o, string tag);
        vec_t v;
        v = mk(r, e, i, d, q, c, o, tag);
        v.l = 1'b1; v.ld = ld;
        return v;
    endfunction

    // Reference behaviour of a 4-bit counter for one clock edge.
    function automatic vec_t model(vec_t s, logic [3:0] cur, logic cur_o, bit sat,
                                   logic [3:0] rv);
        vec_t v;
        v = s;
        v.c = 1'b0;
        v.o = cur_o;
        v.q = cur;
        if (s.r) begin
            v.q = rv; v.o = 1'b0;
        end else if (s.l) begin
            v.q = s.ld; v.o = 1'b0;
        end else if (s.e && (s.i != s.d)) begin
            if (s.i) begin
                if (cur == 4'd15) begin v.c = 1'b1; v.q = sat ? 4'd15 : 4'd0; end
                else v.q = cur + 4'd1;
            end else begin
                if (cur == 4'd0) begin v.c = 1'b1; v.q = sat ? 4'd0 : 4'd15; end
                else v.q = cur - 4'd1;
            end
            v.o = cur_o | v.c;
        end
        return v;
    endfunction

    task automatic drive_a(input vec_t v);
        ra = v.r; ea = v.e; ia = v.i; da = v.d;
`ifdef COMMON_DECINC_COUNTER_LOAD_EN
        la = v.l; lda = v.ld;
`endif
        exp_a.push_back(v);
    endtask

    task automatic drive_b(input vec_t v);
        rb = v.r; eb = v.e; ib = v.i; db = v.d;
`ifdef COMMON_DECINC_COUNTER_LOAD_EN
        lb = v.l; ldb = v.ld;
`endif
        exp_b.push_back(v);
    endtask

    task automatic check(input string who, input vec_t v, input logic [3:0] q,
                         input logic c, o, z, m);
        logic ez, em;
        ez = (v.q == 4'd0);
        em = (v.q == 4'd15);
        n_vec++;
        if (q !== v.q || c !== v.c || o !== v.o || z !== ez || m !== em) begin
            n_err++;
            $display("FAIL %s/%s: got q=%0d c=%0b ovf=%0b is_zero=%0b is_max=%0b, need q=%0d c=%0b ovf=%0b is_zero=%0b is_max=%0b",
                     who, v.tag, q, c, o, z, m, v.q, v.c, v.o, ez, em);
        end
    endtask

    // Advance one edge, compare whatever was queued, then return inputs to idle.
    task automatic tick();
        vec_t v;
        @(posedge clk);
        #1;
        while (exp_a.size() > 0) begin
            v = exp_a.pop_front();
            check("A", v, qa, ca, oa, za, ma);
        end
        while (exp_b.size() > 0) begin
            v = exp_b.pop_front();
            check("B", v, qb, cb, ob, zb, mb);
        end
        ra = 1'b0; ea = 1'b0; ia = 1'b0; da = 1'b0;
        rb = 1'b0; eb = 1'b0; ib = 1'b0; db = 1'b0;
`ifdef COMMON_DECINC_COUNTER_LOAD_EN
        la = 1'b0; lb = 1'b0;
`endif
    endtask

    task automatic sb(input logic r, e, i, d, input logic [3:0] q, input logic c, o,
                      input string tag);
        drive_b(mk(r, e, i, d, q, c, o, tag));
        tick();
    endtask

    initial begin
        logic [3:0] mqa, mqb;
        logic       moa, mob;
        vec_t       s, v;

        // ---- table for instance A (wrap) ----
        tbl.push_back(mk(1, 0, 0, 0, 4'd0, 0, 0, "reset"));
        for (int k = 1; k <= 15; k++)
            tbl.push_back(mk(0, 1, 1, 0, 4'(k), 0, 0, $sformatf("inc%0d", k)));
        tbl.push_back(mk(0, 1, 1, 0, 4'd0, 1, 1, "wrap_up"));
        tbl.push_back(mk(0, 1, 1, 0, 4'd1, 0, 1, "after_wrap"));
        tbl.push_back(mk(0, 1, 0, 1, 4'd0, 0, 1, "dec_to_0"));
        tbl.push_back(mk(1, 1, 1, 0, 4'd0, 0, 0, "reset_mid"));
        tbl.push_back(mk(0, 1, 0, 1, 4'd15, 1, 1, "wrap_down"));
        tbl.push_back(mk(0, 0, 0, 0, 4'd15, 0, 1, "idle_after"));
        tbl.push_back(mk(0, 1, 0, 1, 4'd14, 0, 1, "dec_plain"));
        tbl.push_back(mk(1, 0, 0, 0, 4'd0, 0, 0, "reset2"));
        for (int k = 1; k <= 5; k++)
            tbl.push_back(mk(0, 1, 1, 0, 4'(k), 0, 0, $sformatf("to5_%0d", k)));
        tbl.push_back(mk(0, 1, 1, 1, 4'd5, 0, 0, "both1"));
        tbl.push_back(mk(0, 1, 1, 1, 4'd5, 0, 0, "both2"));
        tbl.push_back(mk(0, 0, 1, 0, 4'd5, 0, 0, "en0_inc"));
        tbl.push_back(mk(0, 0, 0, 1, 4'd5, 0, 0, "en0_dec"));
        tbl.push_back(mk(0, 1, 0, 0, 4'd5, 0, 0, "en_none"));
        tbl.push_back(mk(0, 1, 0, 1, 4'd4, 0, 0, "dec5"));

        foreach (tbl[k]) begin
            drive_a(tbl[k]);
            tick();
        end

        // ---- instance B (saturate, RESET_VALUE 3) ----
        sb(1, 0, 0, 0, 4'd3, 0, 0, "reset");
        for (int k = 4; k <= 14; k++) sb(0, 1, 1, 0, 4'(k), 0, 0, $sformatf("inc%0d", k));
        sb(0, 1, 1, 0, 4'd15, 0, 0, "to_max");
        sb(0, 1, 1, 0, 4'd15, 1, 1, "clamp_hi1");
        sb(0, 1, 1, 0, 4'd15, 1, 1, "clamp_hi2");
        sb(0, 1, 0, 1, 4'd14, 0, 1, "dec_from_max");
        sb(1, 0, 0, 0, 4'd3, 0, 0, "reset2");
        sb(0, 1, 0, 1, 4'd2, 0, 0, "dec2");
        sb(0, 1, 0, 1, 4'd1, 0, 0, "dec1");
        sb(0, 1, 0, 1, 4'd0, 0, 0, "dec0");
        sb(0, 1, 0, 1, 4'd0, 1, 1, "clamp_lo1");
        sb(0, 1, 0, 1, 4'd0, 1, 1, "clamp_lo2");
        sb(1, 0, 0, 0, 4'd3, 0, 0, "reset3");
        for (int k = 4; k <= 10; k++) sb(0, 1, 1, 0, 4'(k), 0, 0, $sformatf("up%0d", k));
        sb(1, 1, 1, 0, 4'd3, 0, 0, "reset_in_stream");
        sb(0, 1, 1, 0, 4'd4, 0, 0, "first_after_reset");

`ifdef COMMON_DECINC_COUNTER_LOAD_EN
        // ---- load path ----
        drive_a(mk(1, 0, 0, 0, 4'd0, 0, 0, "ld_reset")); tick();
        drive_a(mk(0, 1, 0, 1, 4'd15, 1, 1, "ld_setovf")); tick();
        drive_a(mkl(0, 1, 1, 0, 4'd9, 4'd9, 0, 0, "load9_inc")); tick();
        drive_a(mk(0, 1, 1, 0, 4'd10, 0, 0, "after_load")); tick();
        drive_a(mkl(1, 1, 1, 0, 4'd9, 4'd0, 0, 0, "load_vs_reset")); tick();
        drive_b(mkl(1, 1, 0, 1, 4'd9, 4'd3, 0, 0, "load_vs_reset")); tick();
        drive_b(mkl(0, 1, 0, 1, 4'd15, 4'd15, 0, 0, "load15_dec")); tick();
`endif

        // ---- random phase against the reference model ----
        s = mk(1, 0, 0, 0, 4'd0, 0, 0, "rnd_reset");
        v = model(s, 4'd0, 1'b0, 1'b0, 4'd0); mqa = v.q; moa = v.o; drive_a(v);
        v = model(s, 4'd0, 1'b0, 1'b1, 4'd3); mqb = v.q; mob = v.o; drive_b(v);
        tick();
        for (int k = 0; k < 300; k++) begin
            s = mk($urandom_range(0, 24) == 0, $urandom_range(0, 3) != 0,
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   4'd0, 0, 0, $sformatf("rnd%0d", k));
`ifdef COMMON_DECINC_COUNTER_LOAD_EN
            s.l = ($urandom_range(0, 15) == 0);
            s.ld = 4'($urandom_range(0, 15));
`endif
            v = model(s, mqa, moa, 1'b0, 4'd0); mqa = v.q; moa = v.o; drive_a(v);
            s.i = 1'($urandom_range(0, 1));
            s.d = 1'($urandom_range(0, 1));
            v = model(s, mqb, mob, 1'b1, 4'd3); mqb = v.q; mob = v.o; drive_b(v);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
